// File: rtl/sprite_anim_layer_if.sv
// Pixel-path bundle between the sprite layer, its external sprite ROM and the compositor.
// The mirror signal exists only when SPRITE_MIRROR_EN is defined.
interface sprite_anim_layer_if #(
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 14,
    parameter int FRAME_W = 2
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              frame_tick;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              anim_en;
    logic              anim_restart;
`ifdef SPRITE_MIRROR_EN
    logic              mirror;
`endif
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  sprite_idx;
    logic              sprite_hit;
    logic [FRAME_W-1:0] cur_frame;

`ifdef SPRITE_MIRROR_EN
    modport slave (
        input  DrawX, DrawY, blank, frame_tick, pos_x, pos_y, anim_en, anim_restart, mirror, rom_q,
        output rom_address, sprite_idx, sprite_hit, cur_frame
    );
    modport master (
        output DrawX, DrawY, blank, frame_tick, pos_x, pos_y, anim_en, anim_restart, mirror, rom_q,
        input  rom_address, sprite_idx, sprite_hit, cur_frame
    );
`else
    modport slave (
        input  DrawX, DrawY, blank, frame_tick, pos_x, pos_y, anim_en, anim_restart, rom_q,
        output rom_address, sprite_idx, sprite_hit, cur_frame
    );
    modport master (
        output DrawX, DrawY, blank, frame_tick, pos_x, pos_y, anim_en, anim_restart, rom_q,
        input  rom_address, sprite_idx, sprite_hit, cur_frame
    );
`endif
endinterface

// File: rtl/sprite_anim_layer.sv
// Positioned, integer-scaled, frame-animated sprite layer feeding a 1-cycle sync ROM; 3-stage pipeline.
// Optional horizontal flip is compiled in with SPRITE_MIRROR_EN.
module sprite_anim_layer #(
    parameter int SPR_W      = 51,
    parameter int SPR_H      = 43,
    parameter int FRAMES     = 4,
    parameter int IDX_W      = 4,
    parameter int SCALE_LOG2 = 2,
    parameter int ANIM_DIV   = 8,
    parameter int TRANSP_IDX = 0,
    parameter int ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES)
) (
    input  logic vga_clk,
    input  logic reset,
    sprite_anim_layer_if.slave bus
);
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0] WIN_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] WIN_H = 11'(SPR_H << SCALE_LOG2);
    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic [9:0]         act_x_q, act_x_d;
    logic [9:0]         act_y_q, act_y_d;
`ifdef SPRITE_MIRROR_EN
    logic               mirror_q, mirror_d;
`endif
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [FRAME_W-1:0] cur_frame_q, cur_frame_d;
    logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
    logic               win1_q, win1_d;
    logic               win2_q, win2_d;
    logic [IDX_W-1:0]   sprite_idx_q, sprite_idx_d;
    logic               sprite_hit_q, sprite_hit_d;

    logic [10:0]        x11, y11, ax11, ay11, dx, dy;
    logic               in_win;
    logic [ADDR_W-1:0]  lx, ly;

    always_comb begin
        x11  = {1'b0, bus.DrawX};
        y11  = {1'b0, bus.DrawY};
        ax11 = {1'b0, act_x_q};
        ay11 = {1'b0, act_y_q};
        dx   = x11 - ax11;
        dy   = y11 - ay11;
        // 11-bit compare lets the window run off the right/bottom edge without wrapping
        in_win = bus.blank && (x11 >= ax11) && (x11 < ax11 + WIN_W)
                           && (y11 >= ay11) && (y11 < ay11 + WIN_H);
        lx = ADDR_W'(dx >> SCALE_LOG2);
        ly = ADDR_W'(dy >> SCALE_LOG2);
`ifdef SPRITE_MIRROR_EN
        if (mirror_q) begin
            lx = ADDR_W'(SPR_W - 1) - lx;
        end
`endif
        rom_address_d = '0;
        if (in_win) begin
            rom_address_d = ADDR_W'(cur_frame_q) * ADDR_W'(FRAME_SZ) + ly * ADDR_W'(SPR_W) + lx;
        end

        act_x_d = act_x_q;
        act_y_d = act_y_q;
`ifdef SPRITE_MIRROR_EN
        mirror_d = mirror_q;
`endif
        if (bus.frame_tick) begin
            act_x_d = bus.pos_x;
            act_y_d = bus.pos_y;
`ifdef SPRITE_MIRROR_EN
            mirror_d = bus.mirror;
`endif
        end

        div_cnt_d   = div_cnt_q;
        cur_frame_d = cur_frame_q;
        if (bus.anim_restart) begin
            div_cnt_d   = '0;
            cur_frame_d = '0;
        end else if (bus.frame_tick && bus.anim_en) begin
            if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt_d   = '0;
                cur_frame_d = (cur_frame_q == FRAME_W'(FRAMES - 1)) ? '0
                                                                    : cur_frame_q + FRAME_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        win1_d       = in_win;
        win2_d       = win1_q;
        sprite_hit_d = win2_q && (bus.rom_q != IDX_W'(TRANSP_IDX));
        sprite_idx_d = sprite_hit_d ? bus.rom_q : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            act_x_q       <= '0;
            act_y_q       <= '0;
`ifdef SPRITE_MIRROR_EN
            mirror_q      <= 1'b0;
`endif
            div_cnt_q     <= '0;
            cur_frame_q   <= '0;
            rom_address_q <= '0;
            win1_q        <= 1'b0;
            win2_q        <= 1'b0;
            sprite_idx_q  <= '0;
            sprite_hit_q  <= 1'b0;
        end else begin
            act_x_q       <= act_x_d;
            act_y_q       <= act_y_d;
`ifdef SPRITE_MIRROR_EN
            mirror_q      <= mirror_d;
`endif
            div_cnt_q     <= div_cnt_d;
            cur_frame_q   <= cur_frame_d;
            rom_address_q <= rom_address_d;
            win1_q        <= win1_d;
            win2_q        <= win2_d;
            sprite_idx_q  <= sprite_idx_d;
            sprite_hit_q  <= sprite_hit_d;
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.sprite_idx  = sprite_idx_q;
    assign bus.sprite_hit  = sprite_hit_q;
    assign bus.cur_frame   = cur_frame_q;
endmodule

// File: tb/tb_sprite_anim_layer.sv
// Scoreboard bench for sprite_anim_layer: driver pushes model expectations, monitor pops and compares.
module tb_sprite_anim_layer;
    localparam int SPR_W      = 51;
    localparam int SPR_H      = 43;
    localparam int FRAMES     = 4;
    localparam int IDX_W      = 4;
    localparam int SCALE_LOG2 = 2;
    localparam int ANIM_DIV   = 8;
    localparam int TRANSP_IDX = 0;
    localparam int ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES);
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int ROM_N      = SPR_W * SPR_H * FRAMES;

    typedef struct { int due; int idx; bit hit; } pix_t;
    typedef struct { int due; int addr; int frame; } adr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   drive_done = 1'b0;
    int   end_cyc = 0;

    logic [IDX_W-1:0] rom_mem [0:ROM_N-1];
    pix_t pq[$];
    adr_t aq[$];
    pix_t pe;
    adr_t ae;

    // reference-model state
    int m_ax = 0, m_ay = 0, m_ticks = 0;
    bit g_blank = 1'b1, g_en = 1'b0;
    int g_px = 0, g_py = 0;
`ifdef SPRITE_MIRROR_EN
    bit m_mir = 1'b0, g_mir = 1'b0;
`endif

    sprite_anim_layer_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) bus ();

    sprite_anim_layer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_W(IDX_W),
        .SCALE_LOG2(SCALE_LOG2), .ANIM_DIV(ANIM_DIV), .TRANSP_IDX(TRANSP_IDX), .ADDR_W(ADDR_W)
    ) dut (
        .vga_clk(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_address];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            pe = pq.pop_front();
            check("sprite_hit", 32'(bus.sprite_hit), 32'(pe.hit));
            check("sprite_idx", 32'(bus.sprite_idx), 32'(pe.idx));
        end
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ae = aq.pop_front();
            check("rom_address", 32'(bus.rom_address), 32'(ae.addr));
            check("cur_frame", 32'(bus.cur_frame), 32'(ae.frame));
        end
        if (drive_done && cyc >= end_cyc) begin
            check("pending_expectations", 32'(pq.size() + aq.size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int x_in, input int y_in, input bit tick = 1'b0,
                        input bit restart = 1'b0, input bit rst_i = 1'b0);
        pix_t p;
        adr_t a;
        int x, y, sc, fr, lx, ly, addr;
        bit inw;
        x = x_in & 1023;
        y = y_in & 1023;
        rst               = rst_i;
        bus.DrawX         = 10'(x);
        bus.DrawY         = 10'(y);
        bus.blank         = g_blank;
        bus.frame_tick    = tick;
        bus.anim_restart  = restart;
        bus.anim_en       = g_en;
        bus.pos_x         = 10'(g_px);
        bus.pos_y         = 10'(g_py);
`ifdef SPRITE_MIRROR_EN
        bus.mirror        = g_mir;
`endif
        if (rst_i) begin
            m_ax = 0; m_ay = 0; m_ticks = 0;
`ifdef SPRITE_MIRROR_EN
            m_mir = 1'b0;
`endif
            p = '{cyc + 3, 0, 1'b0};
            a = '{cyc + 1, 0, 0};
        end else begin
            sc   = 1 << SCALE_LOG2;
            fr   = (m_ticks / ANIM_DIV) % FRAMES;
            inw  = g_blank && x >= m_ax && x < m_ax + SPR_W * sc
                           && y >= m_ay && y < m_ay + SPR_H * sc;
            addr = 0;
            if (inw) begin
                lx = (x - m_ax) / sc;
                ly = (y - m_ay) / sc;
`ifdef SPRITE_MIRROR_EN
                if (m_mir) lx = SPR_W - 1 - lx;
`endif
                addr = fr * SPR_W * SPR_H + ly * SPR_W + lx;
            end
            p.due = cyc + 3;
            p.hit = inw && (int'(rom_mem[addr]) != TRANSP_IDX);
            p.idx = p.hit ? int'(rom_mem[addr]) : 0;
            if (restart) m_ticks = 0;
            else if (tick && g_en) m_ticks++;
            if (tick) begin
                m_ax = g_px & 1023;
                m_ay = g_py & 1023;
`ifdef SPRITE_MIRROR_EN
                m_mir = g_mir;
`endif
            end
            a = '{cyc + 1, addr, (m_ticks / ANIM_DIV) % FRAMES};
        end
        pq.push_back(p);
        aq.push_back(a);
        @(negedge clk);
    endtask

    initial begin
        int rx, ry;
        for (int i = 0; i < ROM_N; i++) rom_mem[i] = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
        rom_mem[0] = IDX_W'(TRANSP_IDX);
        rom_mem[1] = IDX_W'(5);
        bus.rom_q = '0;
        @(negedge clk);

        // reset then idle at the origin
        step(0, 0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0);

        // window and scale at (100,50)
        g_px = 100; g_py = 50;
        step(0, 0, 1'b1);
        step(103, 50);
        step(104, 50);
        step(304, 50);
        step(303, 50);
        step(99, 50);
        step(100, 54);
        step(303, 221);
        step(303, 222);
        // transparency: entry 0 is transparent, entry 1 holds 5
        step(100, 50);
        step(104, 50);
        g_blank = 1'b0;
        step(104, 50);
        g_blank = 1'b1;

        // position change without a tick keeps the old window
        g_px = 200;
        step(150, 50);
        step(199, 60);
        step(0, 0, 1'b1);
        step(150, 50);
        step(200, 50);

        // animation
        g_px = 100;
        step(0, 0, 1'b1);
        g_en = 1'b1;
        step(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(0, 0, 1'b1);
        step(104, 50);
        for (int i = 0; i < 24; i++) step(0, 0, 1'b1);
        g_en = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 0, 1'b1);
        g_en = 1'b1;
        for (int i = 0; i < 7; i++) step(0, 0, 1'b1);
        step(0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(0, 0, 1'b1);
        step(104, 50);
        step(0, 0, 1'b1);
        step(104, 51);

        // mid-line reset
        g_blank = 1'b0;
        for (int i = 0; i < 3; i++) step(150, 60);
        g_blank = 1'b1;
        step(150, 60, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4 * i, 0);

`ifdef SPRITE_MIRROR_EN
        g_en = 1'b0; g_mir = 1'b1; g_px = 100; g_py = 50;
        step(0, 0, 1'b1);
        step(100, 50);
        step(304 - 1, 50);
        g_mir = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                g_px = $urandom_range(0, 1023);
                g_py = $urandom_range(0, 1023);
            end
            if ($urandom_range(0, 49) == 0) g_en = ~g_en;
`ifdef SPRITE_MIRROR_EN
            if ($urandom_range(0, 49) == 0) g_mir = ~g_mir;
`endif
            g_blank = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 0) begin
                rx = m_ax - 4 + int'($urandom_range(0, 212));
                ry = m_ay - 4 + int'($urandom_range(0, 180));
            end else begin
                rx = $urandom_range(0, 799);
                ry = $urandom_range(0, 524);
            end
            if (rx < 0) rx = 0;
            if (ry < 0) ry = 0;
            step(rx, ry, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        g_blank = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0);
        end_cyc = cyc + 4;
        drive_done = 1'b1;
    end
endmodule

// File: doc/sprite_anim_layer.md
# sprite_anim_layer

Parametrised animated-sprite layer for the VGA pixel path. It maps the current DrawX/DrawY onto a positioned, integer-scaled sprite window and addresses an external synchronous sprite ROM holding FRAMES animation frames. It returns a pipelined palette index with an opaque flag to the downstream compositor. It is the generalisation of the fixed full-screen single-image stretch: arbitrary size, position, scale, frame animation and transparency key.

## Interface
Parameters:
- SPR_W, 51: sprite width in source pixels.
- SPR_H, 43: sprite height in source pixels.
- FRAMES, 4: animation frames stored back-to-back in ROM.
- IDX_W, 4: palette index width.
- SCALE_LOG2, 2: on-screen scale, 2^SCALE_LOG2 screen pixels per source pixel.
- ANIM_DIV, 8: frame_tick pulses per animation step (≥1).
- TRANSP_IDX, 0: palette index treated as transparent.
- ADDR_W, $clog2(SPR_W*SPR_H*FRAMES): ROM address width.

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_tick  in  1  one-cycle pulse per video frame (start of vblank).
- pos_x  in  10  requested sprite left edge, screen pixels.
- pos_y  in  10  requested sprite top edge, screen pixels.
- anim_en  in  1  1 = animation advances.
- anim_restart  in  1  force frame 0 and clear the divider.
- mirror  in  1  horizontal flip (present only with SPRITE_MIRROR_EN).
- rom_address  out  ADDR_W  to external ROM, which has 1-cycle registered read.
- rom_q  in  IDX_W  ROM data.
- sprite_idx  out  IDX_W  palette index.
- sprite_hit  out  1  1 = opaque sprite pixel at this output slot.
- cur_frame  out  $clog2(FRAMES)  current animation frame.

## Operation
- Position latch: on frame_tick, act_x/act_y <= pos_x/pos_y. Between ticks the position is frozen, so there is no tearing. Reset value 0.
- Window: on-screen size is SPR_W<<SCALE_LOG2 by SPR_H<<SCALE_LOG2. in_win = blank & DrawX≥act_x & DrawX<act_x+(SPR_W<<SCALE_LOG2) & same for Y. Compare at 11 bits so the right or bottom edge may extend past 639/479 without wrapping.
- Local coordinates: lx = (DrawX-act_x)>>SCALE_LOG2, ly = (DrawY-act_y)>>SCALE_LOG2.
- Address: cur_frame*SPR_W*SPR_H + ly*SPR_W + lx. Outside the window the address is held at 0.
- Animation:
  - Divider div_cnt counts frame_tick pulses while anim_en=1.
  - At ANIM_DIV-1 it clears, and cur_frame increments, wrapping from FRAMES-1 to 0.
  - anim_en=0 freezes both div_cnt and cur_frame.
  - anim_restart has priority over frame_tick in the same cycle: div_cnt=0, cur_frame=0.
- cur_frame is only sampled into the address; a frame change takes effect on the next video frame, after the tick.
- Output: sprite_hit = in_win (delayed) & (rom_q != TRANSP_IDX). sprite_idx = rom_q when hit, else 0.

## Timing
- Stage 1 (edge after DrawX/DrawY presented): rom_address and in_win registered.
- Stage 2: the ROM returns rom_q; in_win is delayed one more stage.
- Stage 3: sprite_idx and sprite_hit registered.
- Total latency is 3 vga_clk edges from DrawX/DrawY to sprite_idx/sprite_hit. Throughput is 1 pixel/clock with no stalls.
- Reset: rom_address=0, sprite_idx=0, sprite_hit=0, cur_frame=0, div_cnt=0, act_x=act_y=0, and all pipeline valid bits are cleared.
- Reset mid-line: outputs read 0 for 3 clocks after reset deassertion, then follow the pipeline.
- blank=0 forces hit=0 for that pixel, through the pipeline.
- FRAMES=1: cur_frame is held at 0 and the divider still runs harmlessly.

## Configuration
- SPRITE_MIRROR_EN defined: the mirror port exists.
  - mirror is latched on frame_tick, together with the position.
  - When the latched mirror is 1, lx is replaced by SPR_W-1-lx.
- SPRITE_MIRROR_EN undefined: the mirror port is absent and lx is never flipped.

## Test plan
- Reset then idle: reset high 2 clocks, then DrawX=0/DrawY=0 with blank=1 and pos=(0,0) -> sprite_hit=0 for 3 clocks after release, then rom_address=0 and cur_frame=0.
- Window and scale:
  - Setup: pos=(100,50) latched via frame_tick, SCALE_LOG2=2.
  - DrawX=103, DrawY=50 -> rom_address=0.
  - DrawX=104 -> address 1.
  - DrawX=100+204=304 -> in_win=0, hit=0.
  - DrawX=99 -> hit=0.
  - DrawY=54, DrawX=100 -> address 51.
- Animation:
  - With ANIM_DIV=8, FRAMES=4, anim_en=1, issue 8 frame_ticks -> cur_frame=1.
  - 32 ticks total -> cur_frame wraps to 0.
  - anim_en=0 plus 10 ticks -> unchanged.
  - anim_restart coincident with the 8th tick -> cur_frame=0, div_cnt=0.
- Transparency: ROM returns TRANSP_IDX=0 inside the window -> hit=0, idx=0; ROM returns 5 -> hit=1, idx=5, exactly 3 clocks after the DrawX input.
- Position latch: change pos_x mid-frame from 100 to 200 without a tick -> the window stays at 100; after frame_tick -> the window starts at 200.
- Mirror (SPRITE_MIRROR_EN): mirror=1 latched, DrawX=act_x -> lx=50, so rom_address=50 for frame 0.
